// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// default widths/limits and a small state-decoding helper.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_LIM_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_ME = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    // True while a memory access is in flight for either requester.
    function automatic logic is_grant(input arb_state_e s);
        return (s == GNT_IF) || (s == GNT_ME);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data-stage requesters, the arbiter and memory.
// slave: the arbiter's view.  master: the requester/memory side's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    localparam int STRB_W = DATA_W / 8;

    // Fetch port
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic [DATA_W-1:0] IF_RDATA;
    logic              IF_VALID;
    logic              IF_STALL;

    // Data-stage port
    logic              ME_REQ;
    logic              ME_WE;
    logic [ADDR_W-1:0] ME_ADDR;
    logic [DATA_W-1:0] ME_WDATA;
    logic [STRB_W-1:0] ME_WSTRB;
    logic [DATA_W-1:0] ME_RDATA;
    logic              ME_VALID;
    logic              ME_STALL;

    logic              ERR;

    // Memory side
    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [STRB_W-1:0] MEM_WSTRB;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_ACK;

    modport slave (
        input  IF_REQ, IF_ADDR,
        input  ME_REQ, ME_WE, ME_ADDR, ME_WDATA, ME_WSTRB,
        input  MEM_RDATA, MEM_ACK,
        output IF_RDATA, IF_VALID, IF_STALL,
        output ME_RDATA, ME_VALID, ME_STALL, ERR,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB
    );

    modport master (
        output IF_REQ, IF_ADDR,
        output ME_REQ, ME_WE, ME_ADDR, ME_WDATA, ME_WSTRB,
        output MEM_RDATA, MEM_ACK,
        input  IF_RDATA, IF_VALID, IF_STALL,
        input  ME_RDATA, ME_VALID, ME_STALL, ERR,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB
    );

endinterface

// File: rtl/mem_arbiter_arb_timer.sv
// Arbiter timers: saturating count of ME wins while IF waits, and the
// per-access cycle counter used to abort an unacknowledged access.
module arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_starve_inc,
    input  logic i_starve_clr,
    input  logic i_tmo_run,
    input  logic i_tmo_clr,
    output logic o_starve_hit,
    output logic o_tmo_hit
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] r_starve_cnt;
    logic [TW-1:0] r_tmo_cnt;

    // Starvation counter: clears on an IF grant, saturates at the limit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve_cnt <= {SW{1'b0}};
        end else if (i_starve_clr) begin
            r_starve_cnt <= {SW{1'b0}};
        end else if (i_starve_inc && (r_starve_cnt != SW'(STARVE_LIM))) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Timeout counter: counts MEM_EN cycles of the current access only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tmo_cnt <= {TW{1'b0}};
        end else if (i_tmo_clr) begin
            r_tmo_cnt <= {TW{1'b0}};
        end else if (i_tmo_run) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    assign o_starve_hit = (r_starve_cnt == SW'(STARVE_LIM));
    // Hit on the TIMEOUT-th enabled cycle so MEM_EN is high exactly TIMEOUT cycles.
    assign o_tmo_hit    = i_tmo_run && (r_tmo_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data-stage) single-port memory arbiter.
// ME wins ties unless IF has lost STARVE_LIM times in a row; an access
// without MEM_ACK for TIMEOUT cycles completes with ERR and zero data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    mem_arbiter_if.slave   bus
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e        r_state;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [STRB_W-1:0] r_mem_wstrb;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_me_rdata;
    logic              r_me_valid;
    logic              r_err;

    logic w_grant_if;
    logic w_grant_me;
    logic w_starve_hit;
    logic w_tmo_hit;
    logic w_tmo_run;
    logic w_in_grant;

    assign w_in_grant = is_grant(r_state);
    assign w_tmo_run  = w_in_grant & ~bus.MEM_ACK;

    // Grant decision: requests are only considered while IDLE.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_me = 1'b0;
        if (r_state == IDLE) begin
            if (bus.IF_REQ && bus.ME_REQ) begin
                if (w_starve_hit) begin
                    w_grant_if = 1'b1;
                end else begin
                    w_grant_me = 1'b1;
                end
            end else if (bus.IF_REQ) begin
                w_grant_if = 1'b1;
            end else if (bus.ME_REQ) begin
                w_grant_me = 1'b1;
            end else begin
                w_grant_if = 1'b0;
                w_grant_me = 1'b0;
            end
        end else begin
            w_grant_if = 1'b0;
            w_grant_me = 1'b0;
        end
    end

    arb_timer #(
        .STARVE_LIM (STARVE_LIM),
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .CLK          (CLK),
        .RST          (RST),
        .i_starve_inc (w_grant_me & bus.IF_REQ),
        .i_starve_clr (w_grant_if),
        .i_tmo_run    (w_tmo_run),
        .i_tmo_clr    (~w_in_grant),
        .o_starve_hit (w_starve_hit),
        .o_tmo_hit    (w_tmo_hit)
    );

    // Arbiter FSM with all bus-facing outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_wstrb <= {STRB_W{1'b0}};
            r_if_rdata  <= {DATA_W{1'b0}};
            r_if_valid  <= 1'b0;
            r_me_rdata  <= {DATA_W{1'b0}};
            r_me_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_if_valid <= 1'b0;
                    r_me_valid <= 1'b0;
                    r_err      <= 1'b0;
                    if (w_grant_me) begin
                        r_state     <= GNT_ME;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= bus.ME_WE;
                        r_mem_addr  <= bus.ME_ADDR;
                        r_mem_wdata <= bus.ME_WDATA;
                        r_mem_wstrb <= bus.ME_WSTRB;
                    end else if (w_grant_if) begin
                        r_state     <= GNT_IF;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= bus.IF_ADDR;
                        r_mem_wstrb <= {STRB_W{1'b0}};
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GNT_IF: begin
                    if (bus.MEM_ACK) begin
                        r_state    <= DONE;
                        r_mem_en   <= 1'b0;
                        r_if_rdata <= bus.MEM_RDATA;
                        r_if_valid <= 1'b1;
                        r_err      <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state    <= DONE;
                        r_mem_en   <= 1'b0;
                        r_if_rdata <= {DATA_W{1'b0}};
                        r_if_valid <= 1'b1;
                        r_err      <= 1'b1;
                    end else begin
                        r_state <= GNT_IF;
                    end
                end
                GNT_ME: begin
                    if (bus.MEM_ACK) begin
                        r_state    <= DONE;
                        r_mem_en   <= 1'b0;
                        r_me_rdata <= bus.MEM_RDATA;
                        r_me_valid <= 1'b1;
                        r_err      <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state    <= DONE;
                        r_mem_en   <= 1'b0;
                        r_me_rdata <= {DATA_W{1'b0}};
                        r_me_valid <= 1'b1;
                        r_err      <= 1'b1;
                    end else begin
                        r_state <= GNT_ME;
                    end
                end
                DONE: begin
                    // Requests are ignored here, guaranteeing an IDLE cycle between accesses.
                    r_state    <= IDLE;
                    r_if_valid <= 1'b0;
                    r_me_valid <= 1'b0;
                    r_err      <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_en   <= 1'b0;
                    r_if_valid <= 1'b0;
                    r_me_valid <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MEM_EN    = r_mem_en;
    assign bus.MEM_WE    = r_mem_we;
    assign bus.MEM_ADDR  = r_mem_addr;
    assign bus.MEM_WDATA = r_mem_wdata;
    assign bus.MEM_WSTRB = r_mem_wstrb;
    assign bus.IF_RDATA  = r_if_rdata;
    assign bus.IF_VALID  = r_if_valid;
    assign bus.ME_RDATA  = r_me_rdata;
    assign bus.ME_VALID  = r_me_valid;
    assign bus.ERR       = r_err;
    assign bus.IF_STALL  = bus.IF_REQ & ~r_if_valid;
    assign bus.ME_STALL  = bus.ME_REQ & ~r_me_valid;

endmodule
